// File: rtl/block_write_buffer_if.sv
// Store-path and block-writeback signals of the write-combining buffer.
// master drives stores/acks (CPU + memory side), slave is the buffer itself.
interface block_write_buffer_if #(
   parameter int unsigned BLOCK_NUM_BITS = 22
);
   logic                      wr_valid;
   logic                      wr_ready;
   logic [29:0]               wr_addr;
   logic [31:0]               wr_data;
   logic [3:0]                wr_be;
   logic                      flush;
   logic                      mem_req;
   logic                      mem_ack;
   logic [BLOCK_NUM_BITS-1:0] mem_block_num;
   logic [255:0]              mem_block;
   logic [31:0]               mem_mask;
   logic                      busy;

   modport master (
      output wr_valid, wr_addr, wr_data, wr_be, flush, mem_ack,
      input  wr_ready, mem_req, mem_block_num, mem_block, mem_mask, busy
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_be, flush, mem_ack,
      output wr_ready, mem_req, mem_block_num, mem_block, mem_mask, busy
   );
endinterface

// File: rtl/block_write_buffer.sv
// Write-combining buffer: merges word stores byte-wise into one 32-byte block
// image and writes it back to memory under a byte mask via req/ack.
module block_write_buffer #(
   parameter int unsigned IDLE_LIMIT     = 16,
   parameter int unsigned BLOCK_NUM_BITS = 22
) (
   input  logic                 clk,
   input  logic                 reset,
   block_write_buffer_if.slave  bus
);
   localparam int unsigned BYTES   = 32;
   localparam int unsigned BLOCK_W = 256;
   localparam int unsigned CNT_W   = (IDLE_LIMIT > 1) ? $clog2(IDLE_LIMIT) : 1;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e                    state_q;
   logic [CNT_W-1:0]          idle_cnt_q;
   logic [BLOCK_NUM_BITS-1:0] blk_num_q;
   logic [BLOCK_W-1:0]        block_q;
   logic [BYTES-1:0]          mask_q;
   logic                      mem_req_q;
   logic                      busy_q;

   logic [BLOCK_NUM_BITS-1:0] wr_blk;
   logic [2:0]                wr_off;
   logic                      same_blk;
   logic                      wr_ready_c;
   logic                      accept;
   logic [BYTES-1:0]          base_mask;
   logic [BYTES-1:0]          merged_mask_d;
   logic [BLOCK_W-1:0]        merged_block_d;
   logic                      unused_addr_hi;

   assign wr_blk         = bus.wr_addr[3 +: BLOCK_NUM_BITS];
   assign wr_off         = bus.wr_addr[2:0];
   assign unused_addr_hi = ^bus.wr_addr[29:3+BLOCK_NUM_BITS];
   assign same_blk       = (wr_blk == blk_num_q);

   // Only the address compare is combinational; nothing depends on mem_ack here.
   always_comb begin
      wr_ready_c = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_EMPTY: wr_ready_c = 1'b1;
            ST_FILL:  wr_ready_c = same_blk;
            default:  wr_ready_c = 1'b0;
         endcase
      end
   end

   assign accept    = bus.wr_valid && wr_ready_c;
   assign base_mask = (state_q == ST_EMPTY) ? '0 : mask_q;

   // Byte lane g of the block belongs to word g/4, store byte g%4.
   for (genvar g = 0; g < BYTES; g++) begin : g_merge
      logic hit;
      assign hit = (wr_off == 3'(g / 4)) && bus.wr_be[g % 4];
      assign merged_mask_d[g]         = hit | base_mask[g];
      assign merged_block_d[g*8 +: 8] = hit ? bus.wr_data[(g % 4)*8 +: 8]
                                            : block_q[g*8 +: 8];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         idle_cnt_q <= '0;
         blk_num_q  <= '0;
         block_q    <= '0;
         mask_q     <= '0;
         mem_req_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  blk_num_q  <= wr_blk;
                  block_q    <= merged_block_d;
                  mask_q     <= merged_mask_d;
                  idle_cnt_q <= '0;
                  state_q    <= ST_FILL;
                  busy_q     <= 1'b1;
               end
            end

            ST_FILL: begin
               if (bus.flush) begin
                  if (accept) begin
                     block_q <= merged_block_d;
                     mask_q  <= merged_mask_d;
                  end
                  state_q   <= ST_DRAIN;
                  mem_req_q <= 1'b1;
               end else if (accept && (merged_mask_d == '1)) begin
                  block_q   <= merged_block_d;
                  mask_q    <= merged_mask_d;
                  state_q   <= ST_DRAIN;
                  mem_req_q <= 1'b1;
               end else if (bus.wr_valid && !wr_ready_c) begin
                  // Conflicting block: drain now, the store retries once EMPTY.
                  state_q   <= ST_DRAIN;
                  mem_req_q <= 1'b1;
               end else if (accept) begin
                  block_q    <= merged_block_d;
                  mask_q     <= merged_mask_d;
                  idle_cnt_q <= '0;
               end else if (idle_cnt_q == CNT_W'(IDLE_LIMIT - 1)) begin
                  state_q   <= ST_DRAIN;
                  mem_req_q <= 1'b1;
               end else begin
                  idle_cnt_q <= idle_cnt_q + CNT_W'(1);
               end
            end

            ST_DRAIN: begin
               if (bus.mem_ack) begin
                  mask_q     <= '0;
                  idle_cnt_q <= '0;
                  state_q    <= ST_EMPTY;
                  mem_req_q  <= 1'b0;
                  busy_q     <= 1'b0;
               end
            end

            default: begin
               state_q   <= ST_EMPTY;
               mem_req_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.wr_ready      = wr_ready_c;
   assign bus.mem_req       = mem_req_q;
   assign bus.busy          = busy_q;
   assign bus.mem_block_num = blk_num_q;
   assign bus.mem_block     = block_q;
   assign bus.mem_mask      = mask_q;

endmodule

// File: tb/tb_block_write_buffer.sv
// Bench for block_write_buffer: directed scenarios then random traffic,
// all compared against a byte-array model of the buffered block.
module tb_block_write_buffer;
   localparam int unsigned IDLE_LIMIT = 16;
   localparam int unsigned BNB        = 22;

   logic clk = 1'b0;
   logic reset;

   block_write_buffer_if #(.BLOCK_NUM_BITS(BNB)) bus();

   block_write_buffer #(.IDLE_LIMIT(IDLE_LIMIT), .BLOCK_NUM_BITS(BNB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: an open block collecting bytes, or a block waiting for memory.
   bit            m_open;
   bit            m_drain;
   logic [21:0]   m_blk;
   logic [31:0]   m_mask;
   logic [7:0]    m_bytes [32];
   int            m_quiet;

   function automatic logic [21:0] blk_of(input logic [29:0] a);
      return a[24:3];
   endfunction

   function automatic logic model_ready();
      if (reset)   return 1'b0;
      if (m_drain) return 1'b0;
      if (!m_open) return 1'b1;
      return blk_of(bus.wr_addr) == m_blk;
   endfunction

   function automatic logic [255:0] model_block();
      logic [255:0] r = '0;
      for (int b = 0; b < 32; b++)
         if (m_mask[b]) r[b*8 +: 8] = m_bytes[b];
      return r;
   endfunction

   function automatic logic [255:0] masked(input logic [255:0] blk, input logic [31:0] m);
      logic [255:0] r = '0;
      for (int b = 0; b < 32; b++)
         if (m[b]) r[b*8 +: 8] = blk[b*8 +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_open  = 1'b0;
      m_drain = 1'b0;
      m_blk   = '0;
      m_mask  = '0;
      m_quiet = 0;
      for (int b = 0; b < 32; b++) m_bytes[b] = 8'h00;
   endtask

   task automatic model_merge();
      for (int i = 0; i < 4; i++) begin
         if (bus.wr_be[i]) begin
            m_bytes[int'(bus.wr_addr[2:0]) * 4 + i] = bus.wr_data[i*8 +: 8];
            m_mask[int'(bus.wr_addr[2:0]) * 4 + i]  = 1'b1;
         end
      end
   endtask

   task automatic model_step(input logic rdy);
      logic acc;
      acc = bus.wr_valid && rdy;
      if (m_drain) begin
         if (bus.mem_ack) begin
            m_drain = 1'b0;
            m_mask  = '0;
         end
      end else if (!m_open) begin
         if (acc) begin
            m_open  = 1'b1;
            m_blk   = blk_of(bus.wr_addr);
            m_mask  = '0;
            m_quiet = 0;
            model_merge();
         end
      end else begin
         if (acc) model_merge();
         if (bus.flush || (acc && m_mask == 32'hFFFF_FFFF) || (bus.wr_valid && !rdy)) begin
            m_open  = 1'b0;
            m_drain = 1'b1;
         end else if (acc) begin
            m_quiet = 0;
         end else begin
            m_quiet++;
            if (m_quiet == int'(IDLE_LIMIT)) begin
               m_open  = 1'b0;
               m_drain = 1'b1;
            end
         end
      end
   endtask

   task automatic check_outputs(input logic rdy);
      chk("wr_ready", 256'(bus.wr_ready), 256'(rdy));
      chk("mem_req", 256'(bus.mem_req), 256'(m_drain));
      chk("busy", 256'(bus.busy), 256'(m_open | m_drain));
      chk("mem_mask", 256'(bus.mem_mask), 256'(m_mask));
      if (m_open || m_drain) begin
         chk("mem_block_num", 256'(bus.mem_block_num), 256'(m_blk));
         chk("mem_block", masked(bus.mem_block, m_mask), model_block());
      end
   endtask

   // One clock: check at the falling edge, then advance the model on the rising edge.
   task automatic cycle();
      logic rdy;
      @(negedge clk);
      rdy = model_ready();
      check_outputs(rdy);
      @(posedge clk);
      model_step(rdy);
      #1;
   endtask

   task automatic drive(input logic v, input logic [29:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic fl, input logic ack);
      bus.wr_valid = v;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      bus.wr_be    = be;
      bus.flush    = fl;
      bus.mem_ack  = ack;
   endtask

   task automatic idle_in();
      drive(1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_wr_ready"}, 256'(bus.wr_ready), 256'(1'b0));
      chk({tag, "_mem_req"}, 256'(bus.mem_req), 256'(1'b0));
      chk({tag, "_busy"}, 256'(bus.busy), 256'(1'b0));
      chk({tag, "_mem_mask"}, 256'(bus.mem_mask), 256'(32'h0));
   endtask

   logic [255:0] snap_block;
   logic [31:0]  snap_mask;
   logic [21:0]  snap_num;
   int           n;
   int           pv;

   initial begin
      idle_in();
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check_reset_values("rst");
      chk("rst_mem_block", bus.mem_block, 256'h0);
      chk("rst_mem_block_num", 256'(bus.mem_block_num), 256'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Full block of eight words 0x40..0x47
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 30'h40 + 30'(k), 32'(k), 4'hF, 1'b0, 1'b0);
         cycle();
      end
      idle_in();
      chk("full_req", 256'(bus.mem_req), 256'(1'b1));
      chk("full_num", 256'(bus.mem_block_num), 256'(22'd8));
      chk("full_mask", 256'(bus.mem_mask), 256'(32'hFFFF_FFFF));
      for (int k = 0; k < 8; k++)
         chk("full_word", 256'(bus.mem_block[k*32 +: 32]), 256'(k));
      bus.mem_ack = 1'b1;
      cycle();
      idle_in();
      chk("full_req_off", 256'(bus.mem_req), 256'(1'b0));
      chk("full_busy_off", 256'(bus.busy), 256'(1'b0));

      // Single partial store drained by the idle timer
      drive(1'b1, 30'h10, 32'hAABB_CCDD, 4'b0011, 1'b0, 1'b0);
      cycle();
      idle_in();
      n = 0;
      while (bus.mem_req !== 1'b1 && n < 40) begin
         cycle();
         n++;
      end
      chk("idle_latency", 256'(n), 256'(IDLE_LIMIT));
      chk("idle_num", 256'(bus.mem_block_num), 256'(22'd2));
      chk("idle_mask", 256'(bus.mem_mask), 256'(32'h3));
      chk("idle_data", 256'(bus.mem_block[15:0]), 256'(16'hCCDD));
      bus.mem_ack = 1'b1;
      cycle();
      idle_in();
      cycle();

      // Block conflict: held store accepted one cycle after the ack
      drive(1'b1, 30'h08, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0);
      cycle();
      drive(1'b1, 30'h10, 32'hCAFE_0001, 4'hF, 1'b0, 1'b0);
      cycle();
      repeat (3) cycle();
      chk("conflict_ready_low", 256'(bus.wr_ready), 256'(1'b0));
      chk("conflict_drain_num", 256'(bus.mem_block_num), 256'(22'd1));
      bus.mem_ack = 1'b1;
      cycle();
      bus.mem_ack = 1'b0;
      chk("conflict_ready_after_ack", 256'(bus.wr_ready), 256'(1'b1));
      cycle();
      idle_in();
      chk("conflict_mask", 256'(bus.mem_mask), 256'(32'h0000_000F));
      chk("conflict_num", 256'(bus.mem_block_num), 256'(22'd2));
      bus.flush = 1'b1;
      cycle();
      idle_in();
      bus.mem_ack = 1'b1;
      cycle();
      idle_in();

      // Flush merged with a same-block store to word 7, then a long stall
      drive(1'b1, 30'h18, 32'h1111_1111, 4'h1, 1'b0, 1'b0);
      cycle();
      drive(1'b1, 30'h1F, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
      cycle();
      idle_in();
      chk("flush_req", 256'(bus.mem_req), 256'(1'b1));
      chk("flush_mask_hi", 256'(bus.mem_mask[31:28]), 256'(4'hF));
      chk("flush_word7", 256'(bus.mem_block[255:224]), 256'(32'h1234_5678));
      snap_block = bus.mem_block;
      snap_mask  = bus.mem_mask;
      snap_num   = bus.mem_block_num;
      for (int i = 0; i < 50; i++) begin
         drive(1'($urandom), 30'($urandom), $urandom, 4'($urandom), 1'(i), 1'b0);
         cycle();
      end
      idle_in();
      chk("stall_block", bus.mem_block, snap_block);
      chk("stall_mask", 256'(bus.mem_mask), 256'(snap_mask));
      chk("stall_num", 256'(bus.mem_block_num), 256'(snap_num));
      bus.mem_ack = 1'b1;
      cycle();
      idle_in();
      bus.flush = 1'b1;
      repeat (3) cycle();
      idle_in();
      chk("flush_empty_req", 256'(bus.mem_req), 256'(1'b0));

      // Reset in the middle of a drain, then a stray ack
      drive(1'b1, 30'h20, 32'h5555_AAAA, 4'hF, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 30'h0, 32'h0, 4'h0, 1'b1, 1'b0);
      cycle();
      idle_in();
      chk("pre_reset_req", 256'(bus.mem_req), 256'(1'b1));
      reset = 1'b1;
      #1;
      check_reset_values("mid_drain_rst");
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.mem_ack = 1'b1;
      cycle();
      idle_in();
      cycle();

      // Random traffic over three blocks with varying store density
      pv = 60;
      for (int i = 0; i < 800; i++) begin
         if (i % 100 == 0) pv = (pv == 60) ? 8 : 60;
         drive(1'($urandom_range(0, 99) < pv),
               {5'($urandom), 19'd0, 3'($urandom_range(0, 2)), 3'($urandom)},
               $urandom, 4'($urandom),
               1'($urandom_range(0, 19) == 0),
               1'($urandom_range(0, 3) == 0));
         cycle();
      end
      idle_in();
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
